// File: rtl/cou_down_ctrl.sv
// Loadable, enable-gated down-counter with IDLE/RUN/DONE control and a one-cycle
// terminal-count pulse; optional auto-reload from the last loaded value.
module cou_down_ctrl #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic             en,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic             tc_next;

    // Every output is a flop; busy is registered from the next-state decode so it
    // lines up with the state it reports.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            data_out   <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            tc         <= 1'b0;
        end else begin
            state      <= state_next;
            data_out   <= count_next;
            reload_reg <= reload_next;
            busy       <= (state_next == RUN);
            tc         <= tc_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = data_out;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        if (load) begin
            count_next  = data_in;
            reload_next = data_in;
            state_next  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (data_out != '0) begin
                            state_next = RUN;
                        end else begin
                            state_next = DONE;
                            tc_next    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (data_out > ONE) begin
                            count_next = data_out - ONE;
                        end else if (data_out == ONE) begin
                            count_next = '0;
                            tc_next    = 1'b1;
                            if (!AUTO_RELOAD) begin
                                state_next = DONE;
                            end
                        end else if (AUTO_RELOAD) begin
                            // Count already at zero after a pulse: wrap via the reload value.
                            if (reload_reg != '0) begin
                                count_next = reload_reg;
                            end else begin
                                state_next = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    count_next = '0;
                    if (start) begin
                        if (reload_reg != '0) begin
                            count_next = reload_reg;
                            state_next = RUN;
                        end else begin
                            tc_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

endmodule
